ppi_bus_ctrl: RTL

Synchronous bus-cycle controller for the 8255-style PPI. It samples the asynchronous CPU strobes (nCs, nRd, nWr, A) and sequences every access to the port datapaths. Writes produce one-cycle load strobes to PA/PB/PC. It owns the control-word register, executes port-C bit set/reset (BSR) commands, and muxes port read data back to the CPU. It sits between the CPU pins and the port blocks, which take `controlword` and the strobes from it.

---
 rtl/ppi_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: CPU-side bus-cycle sequencer for an 8255-style PPI.
// Synchronises the asynchronous CPU strobes, turns completed write cycles
// into one-cycle load strobes, owns the control word, executes port-C
// bit set/reset commands and returns port data on reads.
module ppi_bus_ctrl #(
  parameter logic [7:0] RESET_CW = 8'h9B
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       nCs,
  input  logic       nRd,
  input  logic       nWr,
  input  logic [1:0] A,
  input  logic [7:0] din,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic [7:0] controlword,
  output logic       pa_we,
  output logic       pb_we,
  output logic       pc_we,
  output logic [7:0] wdata,
  output logic       pc_bit_we,
  output logic [2:0] pc_bit_sel,
  output logic       pc_bit_val,
  output logic       port_clr,
  output logic       bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Strobe synchronisers: bit 0 = s1, bit 1 = s2, bit 2 = s3 (previous s2).
  logic [2:0] cs_q, rd_q, wr_q;
  // Address/data delayed by the same two stages as the strobes, so the
  // sample seen alongside s2 was taken at the same edge as the strobe level.
  logic [1:0] a_s1_q, a_s2_q;
  logic [7:0] din_s1_q, din_s2_q;

  logic cs_s2, cs_s3, rd_s2, rd_s3, wr_s2, wr_s3;
  logic cs_rise, rd_fall, wr_fall, wr_rise;

  logic [1:0] state_q, state_d;
  logic [1:0] rd_sel_q, rd_sel_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cw_q, cw_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_en_q, dout_en_d;
  logic       pa_we_q, pa_we_d;
  logic       pb_we_q, pb_we_d;
  logic       pc_we_q, pc_we_d;
  logic       bit_we_q, bit_we_d;
  logic [2:0] bit_sel_q, bit_sel_d;
  logic       bit_val_q, bit_val_d;
  logic       port_clr_q, port_clr_d;
  logic       bus_err_q, bus_err_d;

  logic [1:0] mux_sel;
  logic [7:0] port_data;

  assign cs_s2 = cs_q[1];
  assign cs_s3 = cs_q[2];
  assign rd_s2 = rd_q[1];
  assign rd_s3 = rd_q[2];
  assign wr_s2 = wr_q[1];
  assign wr_s3 = wr_q[2];

  assign cs_rise = cs_s2 & ~cs_s3;
  assign rd_fall = ~rd_s2 & rd_s3;
  assign wr_fall = ~wr_s2 & wr_s3;
  assign wr_rise = wr_s2 & ~wr_s3;

  // Two-flop synchronisers plus edge-history flop; address/data pipelined alongside.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      cs_q     <= '1;
      rd_q     <= '1;
      wr_q     <= '1;
      a_s1_q   <= '0;
      a_s2_q   <= '0;
      din_s1_q <= '0;
      din_s2_q <= '0;
    end else begin
      cs_q     <= {cs_q[1:0], nCs};
      rd_q     <= {rd_q[1:0], nRd};
      wr_q     <= {wr_q[1:0], nWr};
      a_s1_q   <= A;
      a_s2_q   <= a_s1_q;
      din_s1_q <= din;
      din_s2_q <= din_s1_q;
    end
  end

  // Read-data source: the live address on entry to RD, the latched select afterwards.
  always_comb begin
    mux_sel = (state_q == ST_IDLE) ? a_s2_q : rd_sel_q;
    case (mux_sel)
      2'b00:   port_data = pa_in;
      2'b01:   port_data = pb_in;
      2'b10:   port_data = pc_in;
      default: port_data = '0;
    endcase
  end

  // Bus-cycle FSM and commit decode.
  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    cw_d       = cw_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    pa_we_d    = 1'b0;
    pb_we_d    = 1'b0;
    pc_we_d    = 1'b0;
    bit_we_d   = 1'b0;
    bit_sel_d  = bit_sel_q;
    bit_val_d  = bit_val_q;
    port_clr_d = 1'b0;
    bus_err_d  = bus_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!cs_s2) begin
          if (!wr_s2 && rd_s2) begin
            state_d = ST_WR;
          end else if (!rd_s2 && wr_s2) begin
            state_d  = ST_RD;
            rd_sel_d = a_s2_q;
            if (a_s2_q != 2'b11) begin
              dout_en_d = 1'b1;
              dout_d    = port_data;
            end
          end else if (!rd_s2 && !wr_s2) begin
            state_d   = ST_ERR;
            bus_err_d = 1'b1;
          end
        end
      end

      ST_WR: begin
        // Capture only while the synchronised nWr is still low, so the
        // committed address/data come from inside the strobe window.
        if (!wr_s2) begin
          wr_addr_d = a_s2_q;
          wdata_d   = din_s2_q;
        end
        if (rd_fall) begin
          state_d   = ST_ERR;
          bus_err_d = 1'b1;
        end else if (wr_s2) begin
          // nWr rising takes priority over a simultaneous nCs rise.
          state_d = ST_IDLE;
          if (wr_rise) begin
            case (wr_addr_q)
              2'b00: pa_we_d = 1'b1;
              2'b01: pb_we_d = 1'b1;
              2'b10: pc_we_d = 1'b1;
              default: begin
                if (wdata_q[7]) begin
                  cw_d       = wdata_q;
                  port_clr_d = 1'b1;
                end else begin
                  bit_we_d  = 1'b1;
                  bit_sel_d = wdata_q[3:1];
                  bit_val_d = wdata_q[0];
                end
              end
            endcase
          end
        end else if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end

      ST_RD: begin
        if (wr_fall) begin
          state_d   = ST_ERR;
          bus_err_d = 1'b1;
        end else if (rd_s2 || cs_s2) begin
          state_d = ST_IDLE;
        end else if (rd_sel_q != 2'b11) begin
          dout_en_d = 1'b1;
          dout_d    = port_data;
        end
      end

      default: begin
        if (cs_s2 && rd_s2 && wr_s2) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State, control word, read data and one-cycle strobe registers.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      rd_sel_q   <= '0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      cw_q       <= RESET_CW;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      pa_we_q    <= 1'b0;
      pb_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      bit_we_q   <= 1'b0;
      bit_sel_q  <= '0;
      bit_val_q  <= 1'b0;
      port_clr_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_sel_q   <= rd_sel_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      cw_q       <= cw_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      pa_we_q    <= pa_we_d;
      pb_we_q    <= pb_we_d;
      pc_we_q    <= pc_we_d;
      bit_we_q   <= bit_we_d;
      bit_sel_q  <= bit_sel_d;
      bit_val_q  <= bit_val_d;
      port_clr_q <= port_clr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dout        = dout_q;
  assign dout_en     = dout_en_q;
  assign controlword = cw_q;
  assign pa_we       = pa_we_q;
  assign pb_we       = pb_we_q;
  assign pc_we       = pc_we_q;
  assign wdata       = wdata_q;
  assign pc_bit_we   = bit_we_q;
  assign pc_bit_sel  = bit_sel_q;
  assign pc_bit_val  = bit_val_q;
  assign port_clr    = port_clr_q;
  assign bus_err     = bus_err_q;

endmodule
